// File: rtl/cfg_chain_pkg.sv
// Shared definitions for the configuration-chain loader.
//   state_e     : loader FSM states
//   DEF_*       : default chain length and bitstream word width
//   word_count  : number of bitstream words needed to fill the chain
package cfg_chain_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_CHAIN_LEN = 24;
  localparam int DEF_WORD_W    = 8;

  // ceil(chain_len / word_w)
  function automatic int word_count(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// Readback packer: collects bits leaving the chain tail into words and
// presents them on a valid/ready output stage.
//   prog_clk, pReset : clock, synchronous active-high reset
//   shift_i          : chain advances this cycle; tail_i is captured
//   tail_i           : bit currently at the chain tail
//   flush_i          : no more bits will arrive; emit any partial word
//   m_ready_i        : consumer accepts m_data_o
//   m_data_o/m_valid_o : readback word, bit 0 = first bit out
//   rb_full_o        : output word pending and collection buffer full
//   rb_empty_o       : collection buffer holds no bits
module ccff_rb_packer
  import cfg_chain_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              shift_i,
  input  logic              tail_i,
  input  logic              flush_i,
  input  logic              m_ready_i,
  output logic [WORD_W-1:0] m_data_o,
  output logic              m_valid_o,
  output logic              rb_full_o,
  output logic              rb_empty_o
);

  localparam int RC_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] rb_q, rb_d, m_data_q, m_data_d, keep;
  logic [RC_W-1:0]   cnt_q, cnt_d, base;
  logic              m_valid_q, m_valid_d, complete, xfer;

  always_comb begin
    complete  = (cnt_q == RC_W'(WORD_W)) || (flush_i && (cnt_q != '0));
    // A finished word moves out as soon as the output slot is free or
    // being drained this cycle, so a fresh bit can land in slot 0 at once.
    xfer      = complete && (!m_valid_q || m_ready_i);
    keep      = '0;
    for (int i = 0; i < WORD_W; i++) keep[i] = (RC_W'(i) < cnt_q);
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    if (xfer) begin
      m_data_d  = rb_q & keep;   // partial last word: zero the unfilled bits
      m_valid_d = 1'b1;
    end else if (m_ready_i) begin
      m_valid_d = 1'b0;
    end
    base  = xfer ? '0 : cnt_q;
    rb_d  = rb_q;
    cnt_d = base;
    if (shift_i) begin
      for (int i = 0; i < WORD_W; i++)
        if (RC_W'(i) == base) rb_d[i] = tail_i;
      cnt_d = base + 1'b1;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      rb_q      <= '0;
      cnt_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      rb_q      <= rb_d;
      cnt_q     <= cnt_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_data_o   = m_data_q;
  assign m_valid_o  = m_valid_q;
  assign rb_full_o  = m_valid_q && (cnt_q == RC_W'(WORD_W));
  assign rb_empty_o = (cnt_q == '0);

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serializes bitstream words into ccff_head
// (bit 0 first) and repacks the old chain contents leaving ccff_tail.
//   prog_clk, pReset        : clock, synchronous active-high reset
//   start                   : begin a full chain load (IDLE only)
//   s_data/s_valid/s_ready  : bitstream input words
//   ccff_head, prog_clk_en  : serial bit and shift enable into the chain
//   ccff_tail               : serial bit leaving the chain
//   m_data/m_valid/m_ready  : readback words
//   busy, done              : load in progress / one-cycle completion pulse
module ccff_chain_loader
  import cfg_chain_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              prog_clk_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  localparam int NWORDS    = word_count(CHAIN_LEN, WORD_W);
  localparam int LAST_BITS = (CHAIN_LEN % WORD_W == 0) ? WORD_W : CHAIN_LEN % WORD_W;
  localparam int WB_W      = $clog2(WORD_W + 1);
  localparam int WA_W      = $clog2(NWORDS + 1);

  state_e            state_q;
  logic [WORD_W-1:0] word_q;
  logic [WB_W-1:0]   wbits_q;
  logic [CNT_W-1:0]  bits_left_q;
  logic [WA_W-1:0]   words_acc_q;
  logic              rb_full, rb_empty, shift_now, accept;

  assign shift_now = (state_q == LOAD) && (wbits_q != '0) && (bits_left_q != '0)
                     && !(rb_full && !m_ready);
  // Refill while the last held bit shifts out, so words stream without bubbles.
  assign s_ready   = (state_q == LOAD)
                     && ((wbits_q == '0) || ((wbits_q == WB_W'(1)) && shift_now))
                     && (words_acc_q < WA_W'(NWORDS));
  assign accept      = s_valid && s_ready;
  assign prog_clk_en = shift_now;
  assign ccff_head   = shift_now && word_q[0];
  assign busy        = (state_q == LOAD);
  assign done        = (state_q == DONE);

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q     <= IDLE;
      word_q      <= '0;
      wbits_q     <= '0;
      bits_left_q <= '0;
      words_acc_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q     <= LOAD;
          bits_left_q <= CNT_W'(CHAIN_LEN);
          words_acc_q <= '0;
          wbits_q     <= '0;
        end
        LOAD: begin
          if (accept) begin
            word_q      <= s_data;
            // the final word only carries the chain-length remainder
            wbits_q     <= (words_acc_q == WA_W'(NWORDS - 1)) ? WB_W'(LAST_BITS)
                                                              : WB_W'(WORD_W);
            words_acc_q <= words_acc_q + 1'b1;
          end else if (shift_now) begin
            word_q  <= word_q >> 1;
            wbits_q <= wbits_q - 1'b1;
          end
          if (shift_now) bits_left_q <= bits_left_q - 1'b1;
          // finish once every readback bit has been handed to the output stage
          if ((bits_left_q == '0) && rb_empty) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  ccff_rb_packer #(.WORD_W(WORD_W)) u_rb (
    .prog_clk   (prog_clk),
    .pReset     (pReset),
    .shift_i    (shift_now),
    .tail_i     (ccff_tail),
    .flush_i    ((state_q == LOAD) && (bits_left_q == '0)),
    .m_ready_i  (m_ready),
    .m_data_o   (m_data),
    .m_valid_o  (m_valid),
    .rb_full_o  (rb_full),
    .rb_empty_o (rb_empty)
  );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 24-flop instance (a_*) and a 20-flop
// instance (b_*) share the bitstream and readback handshakes. Each drives a
// model shift chain; expectations come from the words written and the
// previously loaded image.
module tb_ccff_chain_loader;

  logic       clk = 1'b0, rst = 1'b1, start_a = 1'b0, start_b = 1'b0;
  logic       s_valid = 1'b0, m_ready = 1'b1;
  logic [7:0] s_data = 8'h00;

  logic       a_sready, a_head, a_en, a_mvalid, a_busy, a_done;
  logic [7:0] a_mdata;
  logic       b_sready, b_head, b_en, b_mvalid, b_busy, b_done;
  logic [7:0] b_mdata;

  logic [23:0] chain_a = '0;
  logic [19:0] chain_b = '1;
  logic [23:0] img_a   = '0;   // stream last loaded into chain A, bit 0 first

  int   n_chk = 0, n_pass = 0, cyc = 0;
  int   a_shifts = 0, b_shifts = 0, a_dones = 0, b_dones = 0;
  bit   a_heads[$], b_heads[$];
  int   a_encyc[$];
  logic [7:0] a_rb[$], b_rb[$];

  always #5 clk = ~clk;

  ccff_chain_loader #(.CHAIN_LEN(24), .WORD_W(8)) dut_a (
    .prog_clk(clk), .pReset(rst), .start(start_a), .s_data(s_data),
    .s_valid(s_valid), .s_ready(a_sready), .ccff_head(a_head),
    .prog_clk_en(a_en), .ccff_tail(chain_a[23]), .m_data(a_mdata),
    .m_valid(a_mvalid), .m_ready(m_ready), .busy(a_busy), .done(a_done)
  );

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut_b (
    .prog_clk(clk), .pReset(rst), .start(start_b), .s_data(s_data),
    .s_valid(s_valid), .s_ready(b_sready), .ccff_head(b_head),
    .prog_clk_en(b_en), .ccff_tail(chain_b[19]), .m_data(b_mdata),
    .m_valid(b_mvalid), .m_ready(m_ready), .busy(b_busy), .done(b_done)
  );

  // Fabric chain models and event recorders.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_en) begin
      chain_a  <= {chain_a[22:0], a_head};
      a_shifts <= a_shifts + 1;
      a_heads.push_back(a_head);
      a_encyc.push_back(cyc);
    end
    if (b_en) begin
      chain_b  <= {chain_b[18:0], b_head};
      b_shifts <= b_shifts + 1;
      b_heads.push_back(b_head);
    end
    if (a_mvalid && m_ready) a_rb.push_back(a_mdata);
    if (b_mvalid && m_ready) b_rb.push_back(b_mdata);
    if (a_done) a_dones <= a_dones + 1;
    if (b_done) b_dones <= b_dones + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present one word and hold it until the addressed loader takes it.
  task automatic feed(input bit sel, input logic [7:0] w, input bit rnd);
    int g = 0;
    s_data  = w;
    s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      #1;
      if ((sel ? b_sready : a_sready) || g > 300) break;
      g++;
    end
    check("feed_timeout", 32'(g > 300), 32'd0);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic load_a(input logic [7:0] w0, w1, w2, input int gap,
                        input bit hold, input bit rnd);
    int sh0, hb, rb0, d0, g;
    logic [23:0] str, hs, ch;
    str = {w2, w1, w0};
    sh0 = a_shifts; hb = a_heads.size(); rb0 = a_rb.size(); d0 = a_dones;
    if (hold) m_ready = 1'b0;
    start_a = 1'b1; @(posedge clk); #1; start_a = 1'b0;
    check("busy", 32'(a_busy), 32'd1);
    fork
      begin
        feed(1'b0, w0, rnd);
        for (int i = 0; i < gap; i++) begin
          @(posedge clk); #1;
          if (gap >= 13 && i >= gap - 5) check("starve_en", 32'(a_en), 32'd0);
        end
        feed(1'b0, w1, rnd);
        feed(1'b0, w2, rnd);
      end
      begin
        if (hold) begin
          g = 0;
          while (a_shifts - sh0 < 16 && g < 300) begin @(negedge clk); g++; end
          repeat (6) @(negedge clk);
          check("stall_shifts", 32'(a_shifts - sh0), 32'd16);
          check("stall_en", 32'(a_en), 32'd0);
          m_ready = 1'b1;
        end
      end
    join
    g = 0;
    while (a_dones == d0 && g < 400) begin
      @(negedge clk);
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      g++;
    end
    check("done_seen", 32'(a_dones != d0), 32'd1);
    m_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("done_once", 32'(a_dones - d0), 32'd1);
    check("shift_count", 32'(a_shifts - sh0), 32'd24);
    for (int k = 0; k < 24; k++)
      hs[k] = (hb + k < a_heads.size()) ? a_heads[hb + k] : 1'bx;
    check("head_stream", 32'(hs), 32'(str));
    if (gap == 0 && !hold && !rnd && a_encyc.size() >= hb + 24)
      check("consecutive", 32'(a_encyc[hb + 23] - a_encyc[hb]), 32'd23);
    check("rb_count", 32'(a_rb.size() - rb0), 32'd3);
    if (a_rb.size() - rb0 == 3)
      for (int j = 0; j < 3; j++) check("rb_word", 32'(a_rb[rb0 + j]), 32'(img_a[8*j +: 8]));
    for (int k = 0; k < 24; k++) ch[23 - k] = str[k];
    check("chain_image", 32'(chain_a), 32'(ch));
    img_a = str;
  endtask

  initial begin
    repeat (3) @(posedge clk); #1;
    check("rst_sready", 32'({a_sready, b_sready}), 32'd0);
    check("rst_head",   32'({a_head, b_head}), 32'd0);
    check("rst_en",     32'({a_en, b_en}), 32'd0);
    check("rst_mvalid", 32'({a_mvalid, b_mvalid}), 32'd0);
    check("rst_mdata",  32'({a_mdata, b_mdata}), 32'd0);
    check("rst_busy",   32'({a_busy, b_busy}), 32'd0);
    check("rst_done",   32'({a_done, b_done}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    load_a(8'hA5, 8'h3C, 8'h0F, 0, 1'b0, 1'b0);   // from zeroed chain
    load_a(8'hFF, 8'h00, 8'h81, 0, 1'b0, 1'b0);   // reads back A5 3C 0F
    load_a(8'hA5, 8'h3C, 8'h0F, 13, 1'b0, 1'b0);  // starvation gap after word 0
    load_a(8'($urandom), 8'($urandom), 8'($urandom), 0, 1'b1, 1'b0);  // readback stall
    for (int r = 0; r < 3; r++)
      load_a(8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'b1);

    begin : short_chain
      int g;
      bit sr_seen;
      logic [7:0] w0, w1, w2;
      logic [19:0] str, hs, ch;
      w0 = 8'($urandom); w1 = 8'($urandom); w2 = {4'hF, 4'($urandom)};
      str = {w2[3:0], w1, w0};
      sr_seen = 1'b0;
      start_b = 1'b1; @(posedge clk); #1; start_b = 1'b0;
      feed(1'b1, w0, 1'b0); feed(1'b1, w1, 1'b0); feed(1'b1, w2, 1'b0);
      g = 0;
      while (b_dones == 0 && g < 300) begin
        @(negedge clk); if (b_sready) sr_seen = 1'b1; g++;
      end
      repeat (3) @(negedge clk);
      check("b_sready_after_last", 32'(sr_seen), 32'd0);
      check("b_done_once", 32'(b_dones), 32'd1);
      check("b_shift_count", 32'(b_shifts), 32'd20);
      for (int k = 0; k < 20; k++) hs[k] = (k < b_heads.size()) ? b_heads[k] : 1'bx;
      check("b_head_stream", 32'(hs), 32'(str));
      check("b_rb_count", 32'(b_rb.size()), 32'd3);
      if (b_rb.size() == 3) begin
        check("b_rb0", 32'(b_rb[0]), 32'hFF);
        check("b_rb1", 32'(b_rb[1]), 32'hFF);
        check("b_rb_last_pad", 32'(b_rb[2]), 32'h0F);
      end
      for (int k = 0; k < 20; k++) ch[19 - k] = str[k];
      check("b_chain_image", 32'(chain_b), 32'(ch));
    end

    begin : mid_reset
      int sh0, g;
      sh0 = a_shifts;
      start_a = 1'b1; @(posedge clk); #1; start_a = 1'b0;
      feed(1'b0, 8'($urandom), 1'b0);
      feed(1'b0, 8'($urandom), 1'b0);
      g = 0;
      while (a_shifts - sh0 < 10 && g < 300) begin @(negedge clk); g++; end
      check("reach_shift10", 32'(a_shifts - sh0), 32'd10);
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_en",     32'(a_en), 32'd0);
      check("mid_rst_head",   32'(a_head), 32'd0);
      check("mid_rst_sready", 32'(a_sready), 32'd0);
      check("mid_rst_mvalid", 32'(a_mvalid), 32'd0);
      check("mid_rst_mdata",  32'(a_mdata), 32'd0);
      check("mid_rst_busy",   32'(a_busy), 32'd0);
      check("mid_rst_done",   32'(a_done), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      // the chain keeps its partial shift; that is what the next load reads back
      for (int k = 0; k < 24; k++) img_a[k] = chain_a[23 - k];
    end

    load_a(8'($urandom), 8'($urandom), 8'($urandom), 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Configuration-chain controller: drives the far (head) end of the ccff_head → ccff_tail scan chain that threads all switch-block and connection-block mux memories.
- Accepts the bitstream as parallel words and serializes it into ccff_head, one bit per enabled prog_clk cycle.
- Reads back the bits exiting ccff_tail, which are the previous chain contents, and repacks them into words.
- Sits between the bitstream/host interface and the fabric's top-level configuration chain.

Parameters:
- CHAIN_LEN, 24, total configuration flops in the chain (≥1).
- WORD_W, 8, bitstream word width (≥2).
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter (derived).

Ports:
- prog_clk  in  1  programming clock; all logic is on its rising edge.
- pReset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a full chain load.
- s_data  in  WORD_W  bitstream word; bit 0 is shifted first.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader can accept s_data this cycle.
- ccff_head  out  1  serial bit into the chain.
- prog_clk_en  out  1  chain shift enable; the chain advances on prog_clk edges where this is 1.
- ccff_tail  in  1  serial bit out of the chain.
- m_data  out  WORD_W  readback word; bit 0 is the first bit that exited.
- m_valid  out  1  m_data valid.
- m_ready  in  1  consumer accepts m_data.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when the last bit has shifted.

Behaviour:
- Reset: on pReset=1 at an edge, enter IDLE, clear all counters and holding registers. Reset dominates every other input.
- Reset values: s_ready=0, ccff_head=0, prog_clk_en=0, m_valid=0, m_data=0, busy=0, done=0.
- States:
  - IDLE: start=1 → LOAD with bits_left=CHAIN_LEN. start is ignored in LOAD and DONE.
  - LOAD: shifting phase (rules below).
  - DONE: asserts done for exactly one cycle, then returns to IDLE.
- Input holding register: one word deep (word_reg, wbits).
- s_ready = (state==LOAD) && (wbits==0 || (wbits==1 && shift_now)) && words_accepted < ceil(CHAIN_LEN/WORD_W).
- Word accept: a handshake at cycle t loads word_reg; its bit 0 can shift at t+1 at the earliest.
- shift_now = state==LOAD && wbits>0 && bits_left>0 && !(rb_full && !m_ready).
- prog_clk_en = shift_now. ccff_head = word_reg[0] when shift_now, otherwise 0.
- On a shift edge: word_reg shifts right; wbits decrements; bits_left decrements; ccff_tail (sampled in the same cycle, i.e. the old last-flop value) is placed at rb_reg[rb_cnt] and rb_cnt increments.
- Last word: the last word holds only CHAIN_LEN mod WORD_W valid bits (WORD_W if the remainder is 0). Its upper bits are never shifted; wbits is loaded with the valid count.
- Readback:
  - rb_cnt reaching WORD_W, or bits_left reaching 0, moves rb_reg into m_data (zero-padded high bits) and sets m_valid=1 on the next cycle.
  - m_valid holds, with m_data stable, until m_ready=1.
  - rb_full = m_valid pending while rb_reg is also full. In that case shifting stalls (prog_clk_en=0) until m_ready.
- Starvation: s_valid low in mid-load → prog_clk_en=0. The chain holds and resumes without losing a bit.
- Completion: the cycle after bits_left hits 0 and the final readback word has been handed to m_data → DONE.
- busy = state==LOAD. done=1 in DONE only.
- Throughput: with s_valid and m_ready held high, exactly one shift per cycle and no bubbles at word boundaries.
- pReset asserted mid-load: abort immediately. The chain retains a partial shift, and the host must restart the load from scratch.

Decomposition:
- Shared package cfg_chain_pkg:
  - state enum (IDLE, LOAD, DONE);
  - default CHAIN_LEN and WORD_W constants;
  - a function giving the word count, ceil(CHAIN_LEN/WORD_W).
- One natural sub-module, ccff_rb_packer: serial-to-parallel readback buffer with its valid/ready output stage.

Test Plan (CHAIN_LEN=24, WORD_W=8):
- Reset, then start, feed 0xA5, 0x3C, 0x0F with s_valid held high and a zeroed chain model → 24 consecutive prog_clk_en cycles. ccff_head sequence is 1,0,1,0,0,1,0,1 then 0x3C then 0x0F, LSB first. Readback words are 0x00, 0x00, 0x00. done fires once.
- Repeat the load with 0xFF, 0x00, 0x81 → readback equals 0xA5, 0x3C, 0x0F, i.e. the previous contents.
- Drop s_valid for 5 cycles after the first word → prog_clk_en=0 during the gap, and the final chain contents are identical to the no-gap run.
- Hold m_ready=0 from the load start → exactly 16 shifts, then stall. Release m_ready → load completes with correct readback.
- CHAIN_LEN=20: send 3 words with top nibble 0xF in the last → 20 shifts only. The last m_data has upper 4 bits = 0. s_ready stays 0 after 3 words are accepted.
- Assert pReset at shift 10 → all outputs return to reset values next cycle. start is then accepted and a fresh 24-bit load succeeds.
